// File: rtl/ppu_sprite_sched.sv
// ----------------------------------------------------------------------------
// ppu_sprite_sched
//
// Frame-synchronous sprite attribute scheduler. Bus writes land in a pending
// (shadow) bank at any time. All pending entries are copied to the active bank
// in one cycle at the start of vertical blank, so the sprite display units
// never see an attribute change mid-frame.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   chipselect    bus select
//   write         write strobe, qualified by chipselect
//   address       0 = sprite attribute write, 1 = control, others ignored
//   writedata     addr 0: [31:27] sprite id, [26:0] attribute
//                 addr 1: [0] freeze, [1] force_commit (one-shot)
//   hcount        pixel column (reserved, not used for triggering)
//   vcount        current line; VBLANK_LINE marks the first blanking line
//   active_attr   committed attributes, slot k at [k*ATTR_W +: ATTR_W]
//   commit_pulse  one-cycle pulse the cycle after a commit trigger
//   frame_count   number of vblank starts seen, wraps
//   drop_count    writes dropped for an invalid sprite id, saturates at 255
// ----------------------------------------------------------------------------
module ppu_sprite_sched #(
    parameter int NUM_SPRITES = 20,
    parameter int VBLANK_LINE = 480,
    parameter int ATTR_W      = 27
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          chipselect,
    input  logic                          write,
    input  logic [2:0]                    address,
    input  logic [31:0]                   writedata,
    input  logic [9:0]                    hcount,
    input  logic [9:0]                    vcount,
    output logic [NUM_SPRITES*ATTR_W-1:0] active_attr,
    output logic                          commit_pulse,
    output logic [15:0]                   frame_count,
    output logic [7:0]                    drop_count
);

    // State
    logic [NUM_SPRITES-1:0][ATTR_W-1:0] pending_q, pending_d;
    logic [NUM_SPRITES-1:0]             valid_q, valid_d;
    logic [NUM_SPRITES*ATTR_W-1:0]      active_q, active_d;
    logic                               freeze_q, freeze_d;
    logic                               force_q, force_d;
    logic                               vb_prev_q;
    logic                               pulse_q, pulse_d;
    logic [15:0]                        frame_q, frame_d;
    logic [7:0]                         drop_q, drop_d;

    // Decoded bus strobes
    logic       bus_wr;
    logic       attr_wr;
    logic       ctrl_wr;
    logic [4:0] wr_id;
    logic       id_ok;
    logic       vb;
    logic       vb_start;
    logic       commit;

    // hcount is reserved; fold it into a deliberately unused net.
    logic unused_hcount;
    assign unused_hcount = ^hcount;

    assign bus_wr  = chipselect && write;
    assign attr_wr = bus_wr && (address == 3'd0);
    assign ctrl_wr = bus_wr && (address == 3'd1);
    assign wr_id   = writedata[31:27];
    assign id_ok   = 32'(wr_id) < 32'(NUM_SPRITES);

    // Edge detect on the blanking line so a held vcount triggers only once.
    assign vb       = (vcount == 10'(VBLANK_LINE));
    assign vb_start = vb && !vb_prev_q;
    assign commit   = (vb_start && !freeze_q) || force_q;

    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        pending_d = pending_q;
        valid_d   = valid_q;
        active_d  = active_q;
        freeze_d  = freeze_q;
        force_d   = 1'b0;
        pulse_d   = commit;
        frame_d   = frame_q;
        drop_d    = drop_q;

        // Commit reads the pending bank as it was before this cycle's write.
        if (commit) begin
            for (int k = 0; k < NUM_SPRITES; k++) begin
                if (valid_q[k]) begin
                    active_d[k*ATTR_W +: ATTR_W] = pending_q[k];
                end
            end
            valid_d = '0;
        end

        // A write in the commit cycle is applied after the clear so it stays
        // pending for the next commit instead of being lost.
        if (attr_wr) begin
            if (id_ok) begin
                for (int k = 0; k < NUM_SPRITES; k++) begin
                    if (wr_id == 5'(k)) begin
                        pending_d[k] = writedata[ATTR_W-1:0];
                        valid_d[k]   = 1'b1;
                    end
                end
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end

        if (ctrl_wr) begin
            freeze_d = writedata[0];
            force_d  = writedata[1];
        end

        if (vb_start) begin
            frame_d = frame_q + 16'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the pending bank is reset along with its valid bits so a
            // reset mid-frame can never leak stale attributes into a commit.
            pending_q <= '0;
            valid_q   <= '0;
            active_q  <= '0;
            freeze_q  <= 1'b0;
            force_q   <= 1'b0;
            vb_prev_q <= 1'b0;
            pulse_q   <= 1'b0;
            frame_q   <= '0;
            drop_q    <= '0;
        end else begin
            pending_q <= pending_d;
            valid_q   <= valid_d;
            active_q  <= active_d;
            freeze_q  <= freeze_d;
            force_q   <= force_d;
            vb_prev_q <= vb;
            pulse_q   <= pulse_d;
            frame_q   <= frame_d;
            drop_q    <= drop_d;
        end
    end

    assign active_attr  = active_q;
    assign commit_pulse = pulse_q;
    assign frame_count  = frame_q;
    assign drop_count   = drop_q;

endmodule
